// File: rtl/pokey_pot_pkg.sv
// Shared types and constants for the POKEY potentiometer scan sequencer.
package pokey_pot_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDump,
    StScan
  } pot_state_e;

  localparam int unsigned POT_MAX_COUNT      = 228;
  localparam int unsigned POT_DUMP_TICKS     = 2;
  localparam logic [7:0]  ALLPOT_UNUSED_MASK = 8'hF0;

endpackage

// File: rtl/pokey_pot_channel.sv
// One pot channel: holds the latched count and the still-counting flag.
module pokey_pot_channel
  import pokey_pot_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       start_i,
  input  logic       scan_tick_i,
  input  logic [7:0] count_i,
  input  logic       at_max_i,
  input  logic       pot_in_i,
  output logic [7:0] value_o,
  output logic       pending_o
);

  logic [7:0] value_d, value_q;
  logic       pending_d, pending_q;

  always_comb begin
    value_d   = value_q;
    pending_d = pending_q;
    if (clear_i) begin
      pending_d = 1'b0;
    end else if (start_i) begin
      pending_d = 1'b1;
    end else if (scan_tick_i && pending_q && (pot_in_i || at_max_i)) begin
      // At the terminal tick the count equals MAX_COUNT, so one latch path covers both cases.
      value_d   = count_i;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q   <= 8'h00;
      pending_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      pending_q <= pending_d;
    end
  end

  assign value_o   = value_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/pokey_pot_scan_ctrl.sv
// POKEY pot scan sequencer: shared scan counter, capacitor dump control and
// per-channel count latching for the POT0-3 / ALLPOT registers.
module pokey_pot_scan_ctrl
  import pokey_pot_pkg::*;
#(
  parameter int unsigned NUM_POTS   = 4,
  parameter int unsigned MAX_COUNT  = POT_MAX_COUNT,
  parameter int unsigned DUMP_TICKS = POT_DUMP_TICKS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick15_i,
  input  logic                  tick179_i,
  input  logic [7:0]            skctl_i,
  input  logic                  potgo_strobe_i,
  input  logic [NUM_POTS-1:0]   pot_in_i,
  output logic                  pot_rel_o,
  output logic [8*NUM_POTS-1:0] pot_val_o,
  output logic [7:0]            allpot_o,
  output logic                  scan_busy_o,
  output logic                  scan_done_o
);

  localparam logic [7:0] MaxCnt    = MAX_COUNT[7:0];
  localparam logic [7:0] DumpTicks = DUMP_TICKS[7:0];

  pot_state_e    state_q;
  logic [7:0]    cnt_q, dump_q;
  logic          pot_rel_q, busy_q, done_q;
  logic [NUM_POTS-1:0] pending;

  logic scan_tick, init_mode, start, at_max, chan_tick, all_clear;

  assign scan_tick = skctl_i[2] ? tick179_i : tick15_i;
  assign init_mode = (skctl_i[1:0] == 2'b00);
  assign start     = potgo_strobe_i & ~init_mode;
  assign at_max    = (cnt_q == MaxCnt);
  // A restart or init in the same cycle swallows the scan tick.
  assign chan_tick = scan_tick & (state_q == StScan) & ~start & ~init_mode;
  // Pending set once this tick's comparator trips have been applied.
  assign all_clear = ((pending & ~pot_in_i) == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= 8'h00;
      dump_q    <= 8'h00;
      pot_rel_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (init_mode) begin
        state_q   <= StIdle;
        pot_rel_q <= 1'b1;
        busy_q    <= 1'b0;
      end else if (potgo_strobe_i) begin
        state_q   <= StDump;
        cnt_q     <= 8'h00;
        dump_q    <= 8'h00;
        pot_rel_q <= 1'b1;
        busy_q    <= 1'b1;
      end else if (scan_tick) begin
        unique case (state_q)
          StDump: begin
            dump_q <= dump_q + 8'd1;
            if (dump_q + 8'd1 == DumpTicks) begin
              state_q   <= StScan;
              pot_rel_q <= 1'b0;
            end
          end
          StScan: begin
            if (!at_max) begin
              cnt_q <= cnt_q + 8'd1;
            end
            if (at_max || all_clear) begin
              state_q   <= StIdle;
              pot_rel_q <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_POTS; i++) begin : g_chan
    pokey_pot_channel u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (init_mode),
      .start_i    (start),
      .scan_tick_i(chan_tick),
      .count_i    (cnt_q),
      .at_max_i   (at_max),
      .pot_in_i   (pot_in_i[i]),
      .value_o    (pot_val_o[8*i +: 8]),
      .pending_o  (pending[i])
    );
  end

  assign pot_rel_o   = pot_rel_q;
  assign allpot_o    = 8'(pending) & ~ALLPOT_UNUSED_MASK;
  assign scan_busy_o = busy_q;
  assign scan_done_o = done_q;

endmodule

// File: tb/tb_pokey_pot_scan_ctrl.sv
// Self-checking bench for pokey_pot_scan_ctrl: directed scenarios plus a random
// phase, all compared every cycle against a behavioural model of the scan rules.
module tb_pokey_pot_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick15, tick179, potgo;
  logic [7:0]  skctl;
  logic [3:0]  pot_in;
  logic        pot_rel_o, scan_busy_o, scan_done_o;
  logic [31:0] pot_val_o;
  logic [7:0]  allpot_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pokey_pot_scan_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tick15_i      (tick15),
    .tick179_i     (tick179),
    .skctl_i       (skctl),
    .potgo_strobe_i(potgo),
    .pot_in_i      (pot_in),
    .pot_rel_o     (pot_rel_o),
    .pot_val_o     (pot_val_o),
    .allpot_o      (allpot_o),
    .scan_busy_o   (scan_busy_o),
    .scan_done_o   (scan_done_o)
  );

  // Reference model: phase 0=idle, 1=dump, 2=scan; m_n is the scan count N.
  int m_st = 0, m_n = 0, m_d = 0;
  int m_pot[4];
  bit m_pend[4];
  bit m_done = 0;

  task automatic model_step();
    bit tk, any;
    m_done = 0;
    tk = skctl[2] ? tick179 : tick15;
    if (rst) begin
      m_st = 0; m_n = 0; m_d = 0;
      for (int i = 0; i < 4; i++) begin m_pot[i] = 0; m_pend[i] = 0; end
    end else if (skctl[1:0] == 2'b00) begin
      m_st = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
    end else if (potgo) begin
      m_st = 1; m_n = 0; m_d = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 1;
    end else if (tk && m_st == 1) begin
      m_d++;
      if (m_d == 2) m_st = 2;
    end else if (tk && m_st == 2) begin
      any = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i] && (pot_in[i] || m_n == 228)) begin
          m_pot[i] = m_n; m_pend[i] = 0;
        end
        any |= m_pend[i];
      end
      if (m_n == 228 || !any) begin m_st = 0; m_done = 1; end
      if (m_n < 228) m_n++;
    end
  endtask

  function automatic logic [31:0] exp_pot_val();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(m_pot[i]);
    return r;
  endfunction

  function automatic logic [7:0] exp_allpot();
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 4; i++) r[i] = m_pend[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("pot_rel", 32'(pot_rel_o), 32'(m_st != 2));
    check("allpot", 32'(allpot_o), 32'(exp_allpot()));
    check("pot_val", pot_val_o, exp_pot_val());
    check("scan_busy", 32'(scan_busy_o), 32'(m_st != 0));
    check("scan_done", 32'(scan_done_o), 32'(m_done));
  endtask

  task automatic step(input bit t15, input bit t179, input bit pg);
    tick15 = t15; tick179 = t179; potgo = pg;
    cyc();
    tick15 = 0; tick179 = 0; potgo = 0;
  endtask

  initial begin
    int ticks, scan_ticks, dones, cycles;
    bit rel_fell;
    logic [31:0] saved;

    rst = 1; tick15 = 0; tick179 = 0; potgo = 0; skctl = 8'h03; pot_in = 4'h0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 0;
    repeat (10) step(0, 0, 0);
    check("reset_pot_rel", 32'(pot_rel_o), 32'd1);
    check("reset_allpot", 32'(allpot_o), 32'h00);
    check("reset_pot_val", pot_val_o, 32'h0);
    check("reset_busy", 32'(scan_busy_o), 32'd0);

    // Slow scan: pot0 trips after the 50th scan tick, the rest time out.
    step(0, 0, 1);
    ticks = 0; scan_ticks = 0; dones = 0; rel_fell = 0;
    for (int c = 0; c < 1500; c++) begin
      if (m_st == 2 && m_n >= 50) pot_in[0] = 1'b1;
      if (c % 4 == 3) begin
        ticks++;
        if (rel_fell) scan_ticks++;
      end
      step(c % 4 == 3, 0, 0);
      if (!rel_fell && !pot_rel_o) begin
        rel_fell = 1;
        check("t2_dump_ticks", 32'(ticks), 32'd2);
      end
      if (scan_done_o) begin dones++; break; end
    end
    check("t2_done_seen", 32'(dones), 32'd1);
    check("t2_scan_ticks", 32'(scan_ticks), 32'd229);
    check("t2_pot_val", pot_val_o, {8'd228, 8'd228, 8'd228, 8'd50});
    check("t2_allpot", 32'(allpot_o), 32'h00);
    check("t2_pot_rel", 32'(pot_rel_o), 32'd1);
    for (int c = 0; c < 12; c++) begin
      step(c % 4 == 3, 0, 0);
      if (scan_done_o) dones++;
    end
    check("t2_single_done", 32'(dones), 32'd1);

    // Fast scan with every comparator already high; potgo swallows a coincident tick.
    skctl = 8'h07; pot_in = 4'hF;
    step(0, 1, 1);
    cycles = 0;
    for (int c = 0; c < 20; c++) begin
      step(0, 1, 0);
      cycles++;
      if (scan_done_o) break;
    end
    check("t3_done_cycles", 32'(cycles), 32'd3);
    check("t3_pot_val", pot_val_o, 32'h0);
    check("t3_allpot", 32'(allpot_o), 32'h00);
    check("t3_busy", 32'(scan_busy_o), 32'd0);

    // Restart at count 100 after POT1 latched 17.
    pot_in = 4'h0;
    step(0, 0, 1);
    for (int c = 0; c < 400; c++) begin
      if (m_st == 2 && m_n == 100) break;
      if (m_st == 2 && m_n >= 17) pot_in[1] = 1'b1;
      step(0, 1, 0);
    end
    check("t4_pot1_latched", 32'(pot_val_o[15:8]), 32'd17);
    step(0, 1, 1);
    check("t4_allpot", 32'(allpot_o), 32'h0F);
    check("t4_busy", 32'(scan_busy_o), 32'd1);
    check("t4_pot_rel", 32'(pot_rel_o), 32'd1);
    check("t4_pot1_hold", 32'(pot_val_o[15:8]), 32'd17);
    step(0, 1, 0);
    check("t4_pot1_dump", 32'(pot_val_o[15:8]), 32'd17);
    step(0, 1, 0);
    step(0, 1, 0);
    check("t4_pot1_relatch", 32'(pot_val_o[15:8]), 32'd0);
    pot_in = 4'h0;
    for (int c = 0; c < 200; c++) begin
      if (m_st == 2 && m_n == 60) break;
      step(0, 1, 0);
    end

    // Init mode plus potgo mid-scan.
    saved = exp_pot_val();
    skctl = 8'h00;
    step(0, 1, 1);
    check("t5_busy", 32'(scan_busy_o), 32'd0);
    check("t5_allpot", 32'(allpot_o), 32'h00);
    check("t5_done", 32'(scan_done_o), 32'd0);
    check("t5_pot_val", pot_val_o, saved);
    dones = 0;
    repeat (5) begin
      step(0, 1, 0);
      if (scan_done_o) dones++;
    end
    check("t5_no_done", 32'(dones), 32'd0);

    // potgo coincident with a slow tick in IDLE.
    skctl = 8'h03;
    step(1, 0, 1);
    ticks = 0; rel_fell = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 3) ticks++;
      step(c % 4 == 3, 0, 0);
      if (!pot_rel_o) begin rel_fell = 1; break; end
    end
    check("t6_rel_fell", 32'(rel_fell), 32'd1);
    check("t6_dump_ticks", 32'(ticks), 32'd2);

    // Random phase.
    for (int c = 0; c < 6000; c++) begin
      if (c % 97 == 0) begin
        skctl = {5'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0) ? 2'b00 : 2'b11};
      end
      rst = ($urandom_range(0, 2499) == 0);
      potgo = ($urandom_range(0, 299) == 0);
      if (potgo) pot_in = 4'h0;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 39) == 0) pot_in[i] = 1'b1;
      step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), potgo);
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pokey_pot_scan_ctrl.md
Name: pokey_pot_scan_ctrl

Overview:
- Single-clock sequencer for POKEY potentiometer scanning. Replaces per-pot FSMs and gated strobe flip-flops.
- One shared 8-bit scan counter serves four pot channels. It handles the POTGO start and capacitor dump, then latches each channel's count when its comparator input trips.
- Drives the POT0-3 and ALLPOT registers read through the POKEY register interface.

Parameters:
- NUM_POTS, 4, number of pot channels.
- MAX_COUNT, 228, terminal scan count.
- DUMP_TICKS, 2, scan ticks the capacitors are held discharged after POTGO.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tick15  in  1  one-cycle enable at 15 kHz scan rate.
- tick179  in  1  one-cycle enable at 1.79 MHz scan rate.
- skctl  in  8  SKCTL register. Bit 2 = fast scan; bits 1:0 = 00 means init mode.
- potgo_strobe  in  1  one-cycle pulse on a CPU write to POTGO.
- pot_in  in  4  comparator inputs, high once the capacitor crosses threshold.
- pot_rel  out  1  dump-transistor enable; 1 = capacitors discharged.
- pot_val  out  32  packed POT0..POT3 values; POTn = [8n+7:8n].
- allpot  out  8  ALLPOT; bit n = 1 while pot n is still counting; bits 7:4 are always 0.
- scan_busy  out  1  1 in DUMP or SCAN.
- scan_done  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset values: state IDLE, pot_rel=1, pot_val=0, allpot=8'h00, scan_busy=0, scan_done=0, scan counter=0, dump counter=0.
- Scan tick: scan_tick = skctl[2] ? tick179 : tick15. Only scan ticks advance the counters.
- Init override: skctl[1:0]==2'b00 forces IDLE and sets allpot[3:0]=0. pot_val is retained. Init takes priority over potgo_strobe in the same cycle.
- State IDLE:
  - pot_rel=1.
  - On potgo_strobe: go to DUMP, clear both counters, set allpot[3:0]=4'hF.
- State DUMP:
  - pot_rel=1.
  - Each scan tick increments the dump counter.
  - The tick that brings it to DUMP_TICKS moves to SCAN next cycle.
- State SCAN:
  - pot_rel=0.
  - On each scan tick with counter value N, for every channel with allpot[n]=1:
    - if pot_in[n]=1, set POTn<=N and clear allpot[n];
    - else, if N==MAX_COUNT, set POTn<=MAX_COUNT and clear allpot[n].
  - After those updates the counter increments, unless N==MAX_COUNT.
  - On the tick where N==MAX_COUNT: go to IDLE and pulse scan_done the following cycle.
  - Early finish: if all allpot[3:0] bits are clear after a tick, go to IDLE and pulse scan_done.
- Latch timing: a latched value appears on pot_val the cycle after the tick. The first SCAN tick uses N=0, so a pot already high reads 0.
- potgo_strobe in DUMP or SCAN restarts the sequence: back to DUMP, counters cleared, allpot[3:0]=4'hF, pot_val untouched. potgo_strobe takes priority over a coincident scan tick, which is ignored.
- Changing skctl[2] mid-scan takes effect on the next tick. There is no restart.
- Counter is 8-bit unsigned and never exceeds MAX_COUNT.
- rst mid-scan returns every output to its reset value on the next edge.

Decomposition:
- Package pokey_pot_pkg holds:
  - state enum {IDLE, DUMP, SCAN};
  - POT_MAX_COUNT=228;
  - POT_DUMP_TICKS=2;
  - ALLPOT_UNUSED_MASK=8'hF0.
- Sub-module pokey_pot_channel, instantiated NUM_POTS times. Its inputs are clk, rst, start, scan_tick, count, at_max and pot_in. Its outputs are the 8-bit value and the pending bit.

Test Plan:
- Reset, then 10 cycles of no stimulus -> pot_rel=1, allpot=8'h00, pot_val=0, scan_busy=0.
- skctl=8'h03, potgo pulse, tick15 every 4 cycles, pot_in[0] rises after the 50th SCAN tick, pot_in[3:1] stay low -> after 2 DUMP ticks pot_rel=0. After 229 SCAN ticks: POT0=50, POT1=POT2=POT3=228, allpot=8'h00, one scan_done pulse, pot_rel=1.
- skctl=8'h07 (fast), tick179 every cycle, pot_in=4'hF from start -> all POTn=0, allpot clears after the first SCAN tick, early scan_done, state IDLE.
- Restart: potgo at SCAN count 100 with prior POT1=17 -> allpot=8'h0F, state DUMP, counter 0, POT1 still 17 until re-latched.
- skctl written to 8'h00 mid-SCAN, together with a potgo pulse -> state IDLE, allpot=8'h00, no scan_done, pot_val unchanged.
- potgo coincident with tick15 in IDLE -> dump counter stays 0 that cycle; DUMP lasts exactly 2 further ticks.
